// File: rtl/mem_copy_engine_pkg.sv
// Shared types and defaults for the byte-copy engine.
package mem_copy_engine_pkg;

    localparam int MCE_WIDTH      = 8;
    localparam int MCE_ADDR_WIDTH = 8;

    // 3-bit state encodings for the copy FSM.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR     = 3'd3,
        S_WR_GAP = 3'd4,
        S_DONE   = 3'd5
    } mce_state_e;

endpackage

// File: rtl/mem_copy_engine_if.sv
// Valid/ready RAM port driven by the copy engine; ready is registered in the RAM.
interface mem_copy_engine_if #(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  m_valid;
    logic                  m_wr_rd;
    logic [ADDR_WIDTH-1:0] m_addr;
    logic [WIDTH-1:0]      m_wdata;
    logic [WIDTH-1:0]      m_rdata;
    logic                  m_ready;

    modport master (
        output m_valid, m_wr_rd, m_addr, m_wdata,
        input  m_rdata, m_ready
    );

    modport slave (
        input  m_valid, m_wr_rd, m_addr, m_wdata,
        output m_rdata, m_ready
    );
endinterface

// File: rtl/mem_copy_engine.sv
// Byte-at-a-time copy engine: reads SRC, writes DST, ascending, with a running checksum.
// Every transaction is followed by a gap cycle with valid low so a stale registered
// ready from the RAM is never mistaken for a fresh acknowledge.
module mem_copy_engine
    import mem_copy_engine_pkg::*;
#(
    parameter int WIDTH      = MCE_WIDTH,
    parameter int ADDR_WIDTH = MCE_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [ADDR_WIDTH:0]   len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  aborted_o,
    output logic [WIDTH-1:0]      checksum_o,
    mem_copy_engine_if.master     bus
);

    mce_state_e            state_q;
    logic [ADDR_WIDTH-1:0] src_q;
    logic [ADDR_WIDTH-1:0] dst_q;
    logic [ADDR_WIDTH:0]   rem_q;
    logic [WIDTH-1:0]      data_q;
    logic [WIDTH-1:0]      checksum_q;
    logic                  busy_q;
    logic                  done_q;
    logic                  aborted_q;
    logic                  valid_q;
    logic                  wr_rd_q;
    logic [ADDR_WIDTH-1:0] addr_q;

    // Copy FSM with all outputs registered; address/direction only change when valid drops or rises.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            src_q      <= '0;
            dst_q      <= '0;
            rem_q      <= '0;
            data_q     <= '0;
            checksum_q <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            valid_q    <= 1'b0;
            wr_rd_q    <= 1'b0;
            addr_q     <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_i) begin
                        src_q      <= src_addr_i;
                        dst_q      <= dst_addr_i;
                        rem_q      <= len_i;
                        checksum_q <= '0;
                        aborted_q  <= 1'b0;
                        busy_q     <= 1'b1;
                        if (len_i == '0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_RD;
                            valid_q <= 1'b1;
                            wr_rd_q <= 1'b0;
                            addr_q  <= src_addr_i;
                        end
                    end
                end
                S_RD: begin
                    if (bus.m_ready) begin
                        data_q  <= bus.m_rdata;
                        valid_q <= 1'b0;
                        state_q <= S_RD_GAP;
                    end
                end
                S_RD_GAP: begin
                    // Abort here drops the byte just read: it is neither written nor summed.
                    if (abort_i) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        aborted_q <= 1'b1;
                    end else begin
                        state_q <= S_WR;
                        valid_q <= 1'b1;
                        wr_rd_q <= 1'b1;
                        addr_q  <= dst_q;
                    end
                end
                S_WR: begin
                    if (bus.m_ready) begin
                        checksum_q <= checksum_q + data_q;
                        src_q      <= src_q + ADDR_WIDTH'(1);
                        dst_q      <= dst_q + ADDR_WIDTH'(1);
                        rem_q      <= rem_q - (ADDR_WIDTH+1)'(1);
                        valid_q    <= 1'b0;
                        state_q    <= S_WR_GAP;
                    end
                end
                S_WR_GAP: begin
                    if ((rem_q == '0) || abort_i) begin
                        state_q   <= S_DONE;
                        done_q    <= 1'b1;
                        aborted_q <= abort_i;
                    end else begin
                        state_q <= S_RD;
                        valid_q <= 1'b1;
                        wr_rd_q <= 1'b0;
                        addr_q  <= src_q;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign aborted_o   = aborted_q;
    assign checksum_o  = checksum_q;
    assign bus.m_valid = valid_q;
    assign bus.m_wr_rd = wr_rd_q;
    assign bus.m_addr  = addr_q;
    assign bus.m_wdata = data_q;

endmodule
